// File: rtl/ram_master.sv
// Single-request bus initiator for the 16x8 registered-read RAM.
// Accepts one read or write per valid/ready handshake and returns one response per request.
module ram_master #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // Client request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // Client response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // RAM side
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int unsigned CntW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(READ_LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_oe_q, ram_oe_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // The only combinational output; gated by reset so nothing is accepted while it is held.
  assign req_ready = (state_q == StIdle) && !reset;

  always_comb begin
    state_d       = state_q;
    ram_we_d      = ram_we_q;
    ram_oe_d      = ram_oe_q;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          ram_address_d = req_addr;
          ram_data_in_d = req_wdata;
          rsp_write_d   = req_write;
          if (req_write) begin
            ram_we_d = 1'b1;
            state_d  = StWrite;
          end else begin
            ram_oe_d = 1'b1;
            cnt_d    = '0;
            state_d  = StRead;
          end
        end
      end
      StWrite: begin
        // The RAM samples the write on this edge; a single-cycle strobe is enough.
        ram_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StRead: begin
        if (cnt_q == LastCnt) begin
          rsp_rdata_d = ram_data_out;
          ram_oe_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ram_we_q      <= ram_we_d;
      ram_oe_q      <= ram_oe_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;

  we_oe_mutex: assert property (@(posedge clk) disable iff (reset) !(ram_we && ram_oe));

endmodule
